// File: rtl/deint_pkg.sv
// Shared defaults, widths and the bank-state encoding for the block deinterleaver.
package deint_pkg;

  localparam int ROWS_DEF   = 8;
  localparam int COLS_DEF   = 8;
  localparam int DATA_W_DEF = 8;
  localparam int N_DEF      = ROWS_DEF * COLS_DEF;
  localparam int ADDR_W     = $clog2(N_DEF);
  localparam int ROW_W      = $clog2(ROWS_DEF);
  localparam int COL_W      = $clog2(COLS_DEF);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/deint_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
// rd_data holds its value while rd_en is low, so it doubles as a pipeline stage.
module deint_bank_ram #(
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and synchronous read port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/deinterleaver_block.sv
// Block deinterleaver: writes symbols column-major into a frame bank and reads
// them back row-major. Optional macro DEINT_PINGPONG_EN selects two banks
// (write one frame while draining the other); otherwise a single bank is used.
module deinterleaver_block
  import deint_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [DATA_W-1:0] out_data,
  output logic              err_sync
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
`ifdef DEINT_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);

  bank_state_t       bank_state [NB];
  bank_state_t       wr_state, rd_state;
  logic [DATA_W-1:0] ram_rdata [NB];
  logic [DATA_W-1:0] s1_data;

  logic          wr_bank, rd_bank;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_fire, wr_sync_err, wr_last;
  logic          rd_can, rd_issue, out_adv, out_eof_fire;
  logic          s1_valid, s1_bank, s1_sof, s1_eof;
  logic          out_bank;

  // Pick the state/data of the bank each pointer currently addresses.
  always_comb begin
    wr_state = EMPTY;
    rd_state = EMPTY;
    s1_data  = '0;
    for (int b = 0; b < NB; b++) begin
      if (wr_bank == 1'(b)) wr_state = bank_state[b];
      if (rd_bank == 1'(b)) rd_state = bank_state[b];
      if (s1_bank == 1'(b)) s1_data = ram_rdata[b];
    end
  end

  // Handshake qualifiers; a resync symbol is always written as index 0.
  always_comb begin
    in_ready     = (wr_state == EMPTY) || (wr_state == FILLING);
    wr_fire      = in_valid && in_ready;
    wr_sync_err  = wr_fire && in_sof && ((wr_row != '0) || (wr_col != '0));
    wr_last      = wr_fire && !wr_sync_err && (wr_row == ROW_LAST) && (wr_col == COL_LAST);
    wr_addr      = wr_sync_err ? '0 : (AW'(wr_row) * AW'(COLS) + AW'(wr_col));
    out_adv      = !out_valid || out_ready;
    rd_can       = (rd_state == FULL) || ((rd_state == DRAINING) && (rd_addr != '0));
    rd_issue     = rd_can && (!s1_valid || out_adv);
    out_eof_fire = out_valid && out_ready && out_eof;
  end

  // Write-side row/column counters, bank pointer and sync-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row   <= '0;
      wr_col   <= '0;
      wr_bank  <= 1'b0;
      err_sync <= 1'b0;
    end else begin
      err_sync <= wr_sync_err;
      if (wr_fire) begin
        if (wr_sync_err) begin
          wr_row <= RW'(1);
          wr_col <= '0;
        end else if (wr_row == ROW_LAST) begin
          wr_row <= '0;
          wr_col <= (wr_col == COL_LAST) ? '0 : wr_col + CW'(1);
        end else begin
          wr_row <= wr_row + RW'(1);
        end
      end
      if (wr_last) wr_bank <= (NB == 2) ? ~wr_bank : 1'b0;
    end
  end

  // Bank lifecycle; write events and read events never target the same bank at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) bank_state[b] <= EMPTY;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr_fire && (wr_bank == 1'(b)))
          bank_state[b] <= wr_last ? FULL : FILLING;
        else if (rd_issue && (rd_bank == 1'(b)) && (rd_addr == '0))
          bank_state[b] <= DRAINING;
        else if (out_eof_fire && (out_bank == 1'(b)))
          bank_state[b] <= EMPTY;
      end
    end
  end

  // Read address sequencer and RAM-output stage tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr  <= '0;
      rd_bank  <= 1'b0;
      s1_valid <= 1'b0;
      s1_bank  <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (rd_issue) begin
      s1_valid <= 1'b1;
      s1_bank  <= rd_bank;
      s1_sof   <= (rd_addr == '0);
      s1_eof   <= (rd_addr == ADDR_LAST);
      if (rd_addr == ADDR_LAST) begin
        rd_addr <= '0;
        rd_bank <= (NB == 2) ? ~rd_bank : 1'b0;
      end else begin
        rd_addr <= rd_addr + AW'(1);
      end
    end else if (out_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
      out_bank  <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      out_sof   <= s1_valid && s1_sof;
      out_eof   <= s1_valid && s1_eof;
      if (s1_valid) begin
        out_data <= s1_data;
        out_bank <= s1_bank;
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    deint_bank_ram #(
      .DEPTH  (N),
      .AW     (AW),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_bank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (in_data),
      .rd_en   (rd_issue && (rd_bank == 1'(b))),
      .rd_addr (rd_addr),
      .rd_data (ram_rdata[b])
    );
  end

endmodule
